even_parity_transmitter: RTL and testbench

EVEN_PARITY_TRANSMITTER -- requirements
Module: even_parity_transmitter

---
 rtl/even_parity_transmitter.sv | 133 +++++++++++++
 tb/tb_even_parity_transmitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/even_parity_transmitter.sv
// Serial transmitter: start bit, width data bits LSB first, even-parity bit, stop bit.
// Latency: o_tx drops to the start bit one cycle after acceptance; frame lasts (width+3)*divisor cycles.
// Backpressure: o_ready is high only in IDLE; i_valid is ignored while a frame is in flight.
module even_parity_transmitter #(
    parameter int width   = 8,
    parameter int divisor = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_parity
);

    // Counter widths are clamped to at least one bit so width=1 / divisor=1 stay legal.
    localparam int CW = (divisor > 1) ? $clog2(divisor) : 1;
    localparam int IW = (width > 1) ? $clog2(width) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(divisor - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     baud_cnt;
    logic [IW-1:0]     bit_idx;
    logic [width-1:0]  shreg;
    logic              bit_end;

    // A bit period ends when the cycle counter reaches divisor-1.
    assign bit_end = (baud_cnt == CNT_LAST);

    // Frame sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            o_tx     <= 1'b1;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_parity <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_tx     <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (i_valid && o_ready) begin
                        // The word is captured here; later i_data changes cannot reach the line.
                        shreg    <= i_data;
                        o_parity <= ^i_data;
                        state    <= START;
                        o_tx     <= 1'b0;
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        o_tx     <= shreg[0];
                        // Shift so shreg[0] always holds the next data bit to emit.
                        shreg    <= shreg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state <= PARITY;
                            o_tx  <= o_parity;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        o_tx     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        o_tx     <= 1'b1;
                        o_ready  <= 1'b1;
                        o_busy   <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    o_tx     <= 1'b1;
                    o_ready  <= 1'b1;
                    o_busy   <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_even_parity_transmitter.sv
// Bench for even_parity_transmitter: width=8/divisor=4 instance plus a width=1/divisor=1 instance.
// Each frame is predicted as a list of line levels and compared cycle by cycle.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_even_parity_transmitter;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int F  = (W + 3) * D;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         o_ready, o_tx, o_busy, o_parity;

    logic         rst_b;
    logic [0:0]   data_b;
    logic         valid_b;
    logic         ready_b, tx_b, busy_b, parity_b;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    even_parity_transmitter #(.width(W), .divisor(D)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_parity(o_parity)
    );

    even_parity_transmitter #(.width(1), .divisor(1)) dut_b (
        .clk(clk), .rst(rst_b), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_parity(parity_b)
    );

    // Reference: even parity is simply whether the count of ones is odd.
    function automatic logic ref_parity(input logic [W-1:0] d, input int w);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(d[i]);
        return logic'(ones % 2);
    endfunction

    // Reference line level for bit slot n of a frame: start, data LSB first, parity, stop.
    function automatic logic ref_slot(input logic [W-1:0] d, input int w, input int n);
        if (n == 0) return 1'b0;
        if (n <= w) return d[n-1];
        if (n == w + 1) return ref_parity(d, w);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the main DUT is idle and ready.
    task automatic wait_ready(input string name);
        int n = 0;
        while (o_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_ready timed out: o_ready=%b required 1", name, o_ready);
        end
    endtask

    // Called at the first sample after the accepting edge; ends at the first idle sample.
    // perturb_k >= 0 drives a new i_data and an i_valid pulse at that cycle of the frame.
    task automatic check_frame(input logic [W-1:0] d, input string name, input int perturb_k);
        int bad = 0;
        tests++;
        if (o_parity !== ref_parity(d, W)) begin
            errors++;
            $display("FAIL %s parity: got %b required %b", name, o_parity, ref_parity(d, W));
        end
        for (int k = 0; k < F; k++) begin
            tests++;
            if (o_tx !== ref_slot(d, W, k / D) || o_busy !== 1'b1 || o_ready !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 4)
                    $display("FAIL %s cycle %0d: tx=%b busy=%b ready=%b required tx=%b busy=1 ready=0",
                             name, k, o_tx, o_busy, o_ready, ref_slot(d, W, k / D));
            end
            if (k == perturb_k) begin
                i_valid = 1'b1;
                i_data  = ~d;
            end else if (perturb_k >= 0 && k == perturb_k + 1) begin
                i_valid = 1'b0;
            end
            tick();
        end
        tests++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL %s end: ready=%b busy=%b tx=%b required 1 0 1", name, o_ready, o_busy, o_tx);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input string name, input int perturb_k);
        wait_ready(name);
        i_data  = d;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = W'($urandom);
        check_frame(d, name, perturb_k);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_data = 8'hFF;
        rst_b = 1'b1; valid_b = 1'b1; data_b = 1'b1;
        repeat (3) tick();
        tests++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1 || o_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b tx=%b parity=%b required 1 0 1 0",
                     o_ready, o_busy, o_tx, o_parity);
        end
        tests++;
        if (ready_b !== 1'b1 || busy_b !== 1'b0 || tx_b !== 1'b1 || parity_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_b: ready=%b busy=%b tx=%b parity=%b required 1 0 1 0",
                     ready_b, busy_b, tx_b, parity_b);
        end
        i_valid = 1'b0; valid_b = 1'b0;
        tick();
        rst = 1'b0; rst_b = 1'b0;
        repeat (2) tick();
        tests++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b tx=%b required 0 1", o_busy, o_tx);
        end
    endtask

    task automatic test_known_words();
        send(8'h55, "word_55", -1);
        send(8'h07, "word_07", -1);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        wait_ready("b2b");
        i_data = 8'hA5; i_valid = 1'b1;
        tick();
        t1 = cyc;
        i_data = 8'h3C;
        check_frame(8'hA5, "b2b_first", -1);
        tick();
        t2 = cyc;
        i_valid = 1'b0;
        tests++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b ready=%b required 1 0", o_busy, o_ready);
        end
        check_frame(8'h3C, "b2b_second", -1);
        tests++;
        if (t2 - t1 !== F + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", t2 - t1, F + 1);
        end
    endtask

    task automatic test_ignore_inputs();
        send(8'hC3, "ignore", 3 * D + 2);
        repeat (3) tick();
        tests++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL ignore_no_second: busy=%b tx=%b required 0 1", o_busy, o_tx);
        end
    endtask

    task automatic test_mid_frame_reset();
        wait_ready("midrst");
        i_data = 8'h0B; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        // Third data bit occupies slot 3 of the frame.
        repeat (3 * D + 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_parity !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: tx=%b ready=%b busy=%b parity=%b required 1 1 0 0",
                     o_tx, o_ready, o_busy, o_parity);
        end
        for (int k = 0; k < 2 * D; k++) begin
            tests++;
            if (o_tx !== 1'b1) begin
                errors++;
                $display("FAIL midrst_idle cycle %0d: tx=%b required 1", k, o_tx);
            end
            tick();
        end
        send(8'h96, "midrst_resend", -1);
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        for (int n = 0; n < 12; n++) begin
            d = W'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            send(d, "random", -1);
        end
    endtask

    task automatic test_divisor1();
        logic exp_tx [4];
        exp_tx[0] = 1'b0; exp_tx[1] = 1'b1; exp_tx[2] = ref_parity(8'h01, 1); exp_tx[3] = 1'b1;
        data_b = 1'b1; valid_b = 1'b1;
        tick();
        valid_b = 1'b0; data_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (tx_b !== exp_tx[k] || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL div1 cycle %0d: tx=%b busy=%b required tx=%b busy=1", k + 1, tx_b, busy_b, exp_tx[k]);
            end
            tick();
        end
        tests++;
        if (ready_b !== 1'b1 || busy_b !== 1'b0 || tx_b !== 1'b1 || parity_b !== 1'b1) begin
            errors++;
            $display("FAIL div1_end: ready=%b busy=%b tx=%b parity=%b required 1 0 1 1",
                     ready_b, busy_b, tx_b, parity_b);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_known_words();
        test_back_to_back();
        test_ignore_inputs();
        test_mid_frame_reset();
        test_random();
        test_divisor1();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
